// File: rtl/prbs4_checker_if.sv
// ---------------------------------------------------------------------------
// prbs4_checker_if
// Bundles the sample stream and status outputs of the 4-bit LFSR pattern
// checker.
//   data_valid  : data_in is sampled on the checker's clock edge when high
//   data_in     : generator state {Q3,Q2,Q1,Q0}
//   clr_err     : synchronous clear of err_count
//   locked      : checker synchronised to the sequence
//   err_pulse   : one-period flag, mismatch sampled while locked
//   zero_state  : one-period flag, illegal 0000 sampled while hunting/syncing
//   err_count   : saturating count of locked mismatches
// The master modport is the stimulus side; the slave modport is the checker.
// ---------------------------------------------------------------------------
interface prbs4_checker_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 data_valid;
  logic [3:0]           data_in;
  logic                 clr_err;
  logic                 locked;
  logic                 err_pulse;
  logic                 zero_state;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output data_valid, data_in, clr_err,
    input  locked, err_pulse, zero_state, err_count
  );

  modport slave (
    input  data_valid, data_in, clr_err,
    output locked, err_pulse, zero_state, err_count
  );
endinterface

// File: rtl/prbs4_checker.sv
// ---------------------------------------------------------------------------
// prbs4_checker
// Built-in pattern checker for the 4-bit LFSR generator. It samples the
// generator's parallel state, self-synchronises (HUNT -> SYNC -> LOCKED) and,
// once locked, free-runs its own prediction, flagging and counting every
// word that deviates from it.
// Ports:
//   clk    : clock; all flops update on the falling edge, like the generator
//   clear  : asynchronous active-low reset
//   bus    : prbs4_checker_if.slave (sample stream in, status out)
// Parameters:
//   LOCK_COUNT   : consecutive correct predictions after seeding to lock
//   UNLOCK_COUNT : consecutive mispredictions while locked to drop lock
//   ERR_CNT_W    : width of err_count (must match the interface)
// ---------------------------------------------------------------------------
module prbs4_checker #(
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 4,
  parameter int ERR_CNT_W    = 8
) (
  input logic              clk,
  input logic              clear,
  prbs4_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]           LOCK_TARGET   = 4'(LOCK_COUNT);
  localparam logic [3:0]           UNLOCK_TARGET = 4'(UNLOCK_COUNT);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX       = '1;

  state_t               state_q, state_d;
  logic [3:0]           expected_q, expected_d;
  logic [3:0]           match_cnt_q, match_cnt_d;
  logic [3:0]           miss_cnt_q, miss_cnt_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 zero_state_q, zero_state_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [3:0]           match_inc;
  logic [3:0]           miss_inc;
  logic                 count_err;

  // Generator next-state: feedback Q0^Q1 enters at Q3, the rest shift down.
  function automatic logic [3:0] nxt(input logic [3:0] s);
    return {s[0] ^ s[1], s[3], s[2], s[1]};
  endfunction

  assign match_inc = match_cnt_q + 4'd1;
  assign miss_inc  = miss_cnt_q + 4'd1;

  // Sync state machine. In LOCKED the prediction advances from itself, never
  // from the data, so a burst of bad words cannot drag the checker along.
  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    locked_d     = locked_q;
    err_pulse_d  = 1'b0;
    zero_state_d = 1'b0;
    count_err    = 1'b0;

    if (bus.data_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.data_in == 4'b0000) begin
            zero_state_d = 1'b1;
          end else begin
            expected_d  = nxt(bus.data_in);
            match_cnt_d = 4'd0;
            state_d     = SYNC;
          end
        end

        SYNC: begin
          if (bus.data_in == expected_q) begin
            match_cnt_d = match_inc;
            expected_d  = nxt(bus.data_in);
            if (match_inc == LOCK_TARGET) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              miss_cnt_d = 4'd0;
            end
          end else if (bus.data_in != 4'b0000) begin
            expected_d  = nxt(bus.data_in);
            match_cnt_d = 4'd0;
          end else begin
            zero_state_d = 1'b1;
            match_cnt_d  = 4'd0;
            state_d      = HUNT;
          end
        end

        LOCKED: begin
          expected_d = nxt(expected_q);
          if (bus.data_in == expected_q) begin
            miss_cnt_d = 4'd0;
          end else begin
            err_pulse_d = 1'b1;
            count_err   = 1'b1;
            miss_cnt_d  = miss_inc;
            if (miss_inc == UNLOCK_TARGET) begin
              state_d     = HUNT;
              locked_d    = 1'b0;
              match_cnt_d = 4'd0;
              miss_cnt_d  = 4'd0;
            end
          end
        end

        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // Error counter: a clear that coincides with a counted mismatch leaves 1,
  // so the error that arrived with the clear is not lost.
  always_comb begin
    err_count_d = err_count_q;
    if (bus.clr_err) begin
      err_count_d = count_err ? ERR_CNT_W'(1) : '0;
    end else if (count_err && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(negedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= HUNT;
      expected_q   <= 4'b0000;
      match_cnt_q  <= 4'd0;
      miss_cnt_q   <= 4'd0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      zero_state_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      zero_state_q <= zero_state_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.zero_state = zero_state_q;
  assign bus.err_count  = err_count_q;

endmodule
